// File: rtl/bus_to_reg_pkg.sv
// rtl/bus_to_reg_pkg.sv - shared widths, reset value and FSM encoding for the bus-to-register writer
package bus_to_reg_pkg;

    localparam int          DATA_W_DEF    = 16;
    localparam logic [15:0] RESET_VAL_DEF = 16'h0000;

    // Encoding 2'd3 is unused and recovers to ST_IDLE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT2 = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/bus_load_reg.sv
// rtl/bus_load_reg.sv - DATA_W-wide register with synchronous reset and load enable
module bus_load_reg #(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bus_to_reg_1bit_sel.sv
// rtl/bus_to_reg_1bit_sel.sv - captures the data bus into R0/R1 (single or two-beat burst); BUS_TO_REG_PARITY_EN adds beat parity checking
module bus_to_reg_1bit_sel
    import bus_to_reg_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(RESET_VAL_DEF)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] FROM_BUS,
    input  logic              SEL_BUS,
    input  logic              WR_REQ,
    input  logic              WR_BURST,
    input  logic              WR_ABORT,
`ifdef BUS_TO_REG_PARITY_EN
    input  logic              FROM_BUS_PAR,
    output logic              PAR_ERR,
`endif
    output logic              WR_RDY,
    output logic              WR_DONE,
    output logic              WR_ERR,
    output logic [DATA_W-1:0] R0,
    output logic [DATA_W-1:0] R1
);

    logic [1:0] state_d, state_q;
    logic       err_d, err_q;
    logic       xfer;
    logic       beat_ok;
    logic       ld0, ld1;
    logic       wr0, wr1;

    assign WR_RDY  = (state_q == ST_IDLE) || (state_q == ST_BEAT2);
    assign WR_DONE = (state_q == ST_DONE);
    assign WR_ERR  = err_q;
    assign xfer    = WR_REQ && WR_RDY;

`ifdef BUS_TO_REG_PARITY_EN
    logic par_err_d, par_err_q;

    assign beat_ok = (FROM_BUS_PAR == ^FROM_BUS);
    assign PAR_ERR = par_err_q;

    // An aborted BEAT2 offer never becomes a write, so it cannot raise a parity error.
    always_comb begin
        par_err_d = xfer && !beat_ok && !((state_q == ST_BEAT2) && WR_ABORT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`else
    assign beat_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        wr0     = 1'b0;
        wr1     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (WR_BURST) begin
                        wr0     = 1'b1;
                        state_d = ST_BEAT2;
                    end else begin
                        wr0     = !SEL_BUS;
                        wr1     = SEL_BUS;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BEAT2: begin
                if (WR_ABORT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    wr1     = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ld0 = wr0 && beat_ok;
    assign ld1 = wr1 && beat_ok;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    bus_load_reg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_reg0 (
        .clk (CLK),
        .rst (RST),
        .ld  (ld0),
        .d   (FROM_BUS),
        .q   (R0)
    );

    bus_load_reg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_reg1 (
        .clk (CLK),
        .rst (RST),
        .ld  (ld1),
        .d   (FROM_BUS),
        .q   (R1)
    );

endmodule

// File: tb/tb_bus_to_reg_1bit_sel.sv
// tb/tb_bus_to_reg_1bit_sel.sv - directed vector table plus randomized run against a transaction-level model
module tb_bus_to_reg_1bit_sel;

    logic        clk;
    logic        rst;
    logic [15:0] from_bus;
    logic        sel_bus;
    logic        wr_req;
    logic        wr_burst;
    logic        wr_abort;
    logic        wr_rdy;
    logic        wr_done;
    logic        wr_err;
    logic [15:0] r0;
    logic [15:0] r1;
`ifdef BUS_TO_REG_PARITY_EN
    logic        from_bus_par;
    logic        par_err;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    bus_to_reg_1bit_sel dut (
        .CLK          (clk),
        .RST          (rst),
        .FROM_BUS     (from_bus),
        .SEL_BUS      (sel_bus),
        .WR_REQ       (wr_req),
        .WR_BURST     (wr_burst),
        .WR_ABORT     (wr_abort),
`ifdef BUS_TO_REG_PARITY_EN
        .FROM_BUS_PAR (from_bus_par),
        .PAR_ERR      (par_err),
`endif
        .WR_RDY       (wr_rdy),
        .WR_DONE      (wr_done),
        .WR_ERR       (wr_err),
        .R0           (r0),
        .R1           (r1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the bank as an array, plus "waiting for beat 2" and "completion cycle" flags.
    logic [15:0] m_reg [2];
    bit          m_wait2;
    bit          m_cool;
    bit          m_err;
    bit          m_par_err;

    task automatic model_step(input bit f_rst, input bit f_req, input bit f_burst,
                              input bit f_sel, input bit f_abort,
                              input logic [15:0] f_data, input bit f_par_bad);
        bit accepted;
        bit n_wait2, n_cool, n_err;
        n_wait2 = 0; n_cool = 0; n_err = 0;
        if (f_rst) begin
            m_reg[0] = 16'h0000;
            m_reg[1] = 16'h0000;
            m_wait2 = 0; m_cool = 0; m_err = 0; m_par_err = 0;
            return;
        end
        accepted = f_req && !m_cool;
        m_par_err = accepted && f_par_bad && !(m_wait2 && f_abort);
        if (m_wait2) begin
            if (f_abort) n_err = 1;
            else if (accepted) begin
                if (!f_par_bad) m_reg[1] = f_data;
                n_cool = 1;
            end else n_wait2 = 1;
        end else if (accepted) begin
            if (f_burst) begin
                if (!f_par_bad) m_reg[0] = f_data;
                n_wait2 = 1;
            end else begin
                if (!f_par_bad) m_reg[f_sel] = f_data;
                n_cool = 1;
            end
        end
        m_wait2 = n_wait2;
        m_cool  = n_cool;
        m_err   = n_err;
    endtask

    // Drive one cycle's inputs at the falling edge, clock them, and come back to the next falling edge.
    task automatic cycle(input bit f_rst, input bit f_req, input bit f_burst, input bit f_sel,
                         input bit f_abort, input logic [15:0] f_data, input bit f_par_bad);
        rst      = f_rst;
        wr_req   = f_req;
        wr_burst = f_burst;
        sel_bus  = f_sel;
        wr_abort = f_abort;
        from_bus = f_data;
`ifdef BUS_TO_REG_PARITY_EN
        from_bus_par = (^f_data) ^ f_par_bad;
`endif
        @(posedge clk);
        model_step(f_rst, f_req, f_burst, f_sel, f_abort, f_data, f_par_bad);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        bit          rst, req, burst, sel, abort;
        logic [15:0] data;
        bit          e_rdy, e_done, e_err;
        logic [15:0] e_r0, e_r1;
    } vec_t;

    vec_t vecs [20];

    initial begin
        //          rst req bur sel abt data      rdy don err r0        r1
        vecs[0]  = '{1, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000};
        vecs[1]  = '{1, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000};
        vecs[2]  = '{0, 1, 0, 1, 0, 16'hA5A5, 0, 1, 0, 16'h0000, 16'hA5A5};
        vecs[3]  = '{0, 0, 0, 0, 0, 16'hFFFF, 1, 0, 0, 16'h0000, 16'hA5A5};
        vecs[4]  = '{0, 1, 1, 1, 0, 16'h1234, 1, 0, 0, 16'h1234, 16'hA5A5};
        vecs[5]  = '{0, 1, 0, 0, 0, 16'hABCD, 0, 1, 0, 16'h1234, 16'hABCD};
        vecs[6]  = '{0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h1234, 16'hABCD};
        vecs[7]  = '{0, 1, 1, 0, 0, 16'h1111, 1, 0, 0, 16'h1111, 16'hABCD};
        vecs[8]  = '{0, 1, 0, 0, 1, 16'h2222, 1, 0, 1, 16'h1111, 16'hABCD};
        vecs[9]  = '{0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h1111, 16'hABCD};
        vecs[10] = '{0, 1, 0, 0, 0, 16'h0001, 0, 1, 0, 16'h0001, 16'hABCD};
        vecs[11] = '{0, 1, 0, 0, 0, 16'h0002, 1, 0, 0, 16'h0001, 16'hABCD};
        vecs[12] = '{0, 1, 0, 0, 0, 16'h0003, 0, 1, 0, 16'h0003, 16'hABCD};
        vecs[13] = '{0, 1, 0, 0, 0, 16'h0004, 1, 0, 0, 16'h0003, 16'hABCD};
        vecs[14] = '{0, 1, 1, 0, 0, 16'h5555, 1, 0, 0, 16'h5555, 16'hABCD};
        vecs[15] = '{1, 1, 0, 1, 0, 16'h9999, 1, 0, 0, 16'h0000, 16'h0000};
        vecs[16] = '{0, 0, 0, 0, 1, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000};
        vecs[17] = '{0, 1, 1, 0, 0, 16'h7777, 1, 0, 0, 16'h7777, 16'h0000};
        vecs[18] = '{0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h7777, 16'h0000};
        vecs[19] = '{0, 0, 0, 0, 1, 16'h8888, 1, 0, 1, 16'h7777, 16'h0000};

        rst = 1; wr_req = 0; wr_burst = 0; sel_bus = 0; wr_abort = 0; from_bus = '0;
`ifdef BUS_TO_REG_PARITY_EN
        from_bus_par = 1'b0;
`endif
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            cycle(vecs[i].rst, vecs[i].req, vecs[i].burst, vecs[i].sel, vecs[i].abort, vecs[i].data, 1'b0);
            chk("vec_rdy",  i, {15'd0, wr_rdy},  {15'd0, vecs[i].e_rdy});
            chk("vec_done", i, {15'd0, wr_done}, {15'd0, vecs[i].e_done});
            chk("vec_err",  i, {15'd0, wr_err},  {15'd0, vecs[i].e_err});
            chk("vec_r0",   i, r0, vecs[i].e_r0);
            chk("vec_r1",   i, r1, vecs[i].e_r1);
        end

        // WR_ERR is a single-cycle pulse; BEAT2 waits indefinitely without a timeout.
        cycle(0, 0, 0, 0, 0, 16'h0000, 1'b0);
        chk("err_clear", 0, {15'd0, wr_err}, 16'd0);
        cycle(0, 1, 1, 0, 0, 16'hC0DE, 1'b0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 16'h0000, 1'b0);
        chk("wait_rdy", 0, {15'd0, wr_rdy}, 16'd1);
        cycle(0, 1, 0, 0, 0, 16'hBEEF, 1'b0);
        chk("late_beat2_r1",   0, r1, 16'hBEEF);
        chk("late_beat2_done", 0, {15'd0, wr_done}, 16'd1);

        for (int n = 0; n < 600; n++) begin
            bit f_rst, f_req, f_burst, f_sel, f_abort, f_bad;
            logic [15:0] f_data;
            f_rst   = ($urandom_range(0, 49) == 0);
            f_req   = ($urandom_range(0, 9) < 7);
            f_burst = ($urandom_range(0, 9) < 4);
            f_sel   = $urandom_range(0, 1) == 1;
            f_abort = ($urandom_range(0, 9) < 2);
            f_data  = 16'($urandom);
`ifdef BUS_TO_REG_PARITY_EN
            f_bad   = ($urandom_range(0, 9) == 0);
`else
            f_bad   = 1'b0;
`endif
            cycle(f_rst, f_req, f_burst, f_sel, f_abort, f_data, f_bad);
            chk("rnd_rdy",  n, {15'd0, wr_rdy},  {15'd0, !m_cool});
            chk("rnd_done", n, {15'd0, wr_done}, {15'd0, m_cool});
            chk("rnd_err",  n, {15'd0, wr_err},  {15'd0, m_err});
            chk("rnd_r0",   n, r0, m_reg[0]);
            chk("rnd_r1",   n, r1, m_reg[1]);
`ifdef BUS_TO_REG_PARITY_EN
            chk("rnd_par_err", n, {15'd0, par_err}, {15'd0, m_par_err});
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
